// File: rtl/fir_pkt_arbiter.sv
// Packet-level round-robin arbiter that shares one FIR stream between two AXI-Stream requesters.
// A grant is held for a whole packet; packets longer than MAX_BEATS are cut with a forced tlast.
module fir_pkt_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,
  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tlast,
  output logic                  s01_axis_tready,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  output logic                  m00_axis_tuser,
  input  logic                  m00_axis_tready,
  output logic                  ovf_err
);

  localparam int CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tuser_q, tuser_d;
  logic             ovf_q, ovf_d;

  logic                  gidx;
  logic [DATA_WIDTH-1:0] selData;
  logic                  selValid, selLast, atMax, nxtGrant;

  assign gidx     = (state_q == GRANT1);
  assign selData  = gidx ? s01_axis_tdata  : s00_axis_tdata;
  assign selValid = gidx ? s01_axis_tvalid : s00_axis_tvalid;
  assign selLast  = gidx ? s01_axis_tlast  : s00_axis_tlast;
  assign atMax    = (cnt_q == CNT_W'(MAX_BEATS - 1));
  // A lone requester wins outright; on contention the priority pointer decides.
  assign nxtGrant = (s00_axis_tvalid & s01_axis_tvalid) ? prio_q : s01_axis_tvalid;

  assign m00_axis_tuser = tuser_q;
  assign ovf_err        = ovf_q;

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    cnt_d           = cnt_q;
    tuser_d         = tuser_q;
    ovf_d           = ovf_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s00_axis_tvalid | s01_axis_tvalid) begin
          state_d = nxtGrant ? GRANT1 : GRANT0;
          tuser_d = nxtGrant;
          cnt_d   = '0;
        end
      end
      GRANT0, GRANT1: begin
        m00_axis_tdata  = selData;
        m00_axis_tvalid = selValid;
        m00_axis_tlast  = selLast | atMax;
        s00_axis_tready = ~gidx & m00_axis_tready;
        s01_axis_tready =  gidx & m00_axis_tready;
        if (selValid & m00_axis_tready) begin
          // The beat at the length limit closes the packet even without input tlast.
          if (selLast | atMax) begin
            state_d = IDLE;
            prio_d  = ~gidx;
            if (!selLast) ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      tuser_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      tuser_q <= tuser_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fir_pkt_arbiter.sv
// Directed bench for fir_pkt_arbiter (MAX_BEATS=4): grants, round-robin, stalls, overflow, reset.
module tb_fir_pkt_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] s00_axis_tdata, s01_axis_tdata, m00_axis_tdata;
  logic        s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic        s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser, m00_axis_tready;
  logic        ovf_err;

  int compared   = 0;
  int mismatched = 0;

  fir_pkt_arbiter #(.DATA_WIDTH(16), .MAX_BEATS(4)) dut (
    .aclk(aclk), .areset(areset),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tlast(s00_axis_tlast), .s00_axis_tready(s00_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tvalid(s01_axis_tvalid),
    .s01_axis_tlast(s01_axis_tlast), .s01_axis_tready(s01_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tlast(m00_axis_tlast), .m00_axis_tuser(m00_axis_tuser),
    .m00_axis_tready(m00_axis_tready), .ovf_err(ovf_err)
  );

  always #5 aclk = ~aclk;

  // Inputs change on the falling edge; outputs are checked 1 ns later, well before the rising edge.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [15:0] d0, input logic l0,
                               input logic v1, input logic [15:0] d1, input logic l1,
                               input logic rdy);
    @(negedge aclk);
    areset          = rst;
    s00_axis_tvalid = v0;
    s00_axis_tdata  = d0;
    s00_axis_tlast  = l0;
    s01_axis_tvalid = v1;
    s01_axis_tdata  = d1;
    s01_axis_tlast  = l1;
    m00_axis_tready = rdy;
    #1;
  endtask

  // Data and tlast only matter while m00_axis_tvalid is expected high.
  task automatic checkOutput(input string tag, input logic er0, input logic er1, input logic emv,
                             input logic [15:0] emd, input logic eml, input logic emu,
                             input logic eovf);
    logic [21:0] obs, exp;
    obs = {s00_axis_tready, s01_axis_tready, m00_axis_tvalid,
           emv ? m00_axis_tdata : 16'h0, emv ? m00_axis_tlast : 1'b0, m00_axis_tuser, ovf_err};
    exp = {er0, er1, emv, emv ? emd : 16'h0, emv ? eml : 1'b0, emu, eovf};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed {r0,r1,v,data,last,user,ovf}=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    areset = 1'b1;
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tlast = 1'b0;
    s01_axis_tvalid = 1'b0; s01_axis_tdata = '0; s01_axis_tlast = 1'b0;
    m00_axis_tready = 1'b0;

    applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("reset", 0, 0, 0, 16'h0, 0, 0, 0);

    // Single 3-beat packet from s00
    applyStimulus(0, 1, 16'h0001, 0, 0, 16'h0, 0, 1);
    checkOutput("p1_arb", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0001, 0, 0, 16'h0, 0, 1);
    checkOutput("p1_b1", 1, 0, 1, 16'h0001, 0, 0, 0);
    applyStimulus(0, 1, 16'h0002, 0, 0, 16'h0, 0, 1);
    checkOutput("p1_b2", 1, 0, 1, 16'h0002, 0, 0, 0);
    applyStimulus(0, 1, 16'h0003, 1, 0, 16'h0, 0, 1);
    checkOutput("p1_b3", 1, 0, 1, 16'h0003, 1, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("p1_idle", 0, 0, 0, 16'h0, 0, 0, 0);

    // Simultaneous requests right after reset: s00 first, then s01
    applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("rst2", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0010, 1, 1, 16'h0020, 1, 1);
    checkOutput("both_arb", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0010, 1, 1, 16'h0020, 1, 1);
    checkOutput("both_s00", 1, 0, 1, 16'h0010, 1, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0020, 1, 1);
    checkOutput("both_gap", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0020, 1, 1);
    checkOutput("both_s01", 0, 1, 1, 16'h0020, 1, 1, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("both_idle", 0, 0, 0, 16'h0, 0, 1, 0);

    // Back-to-back single-beat packets alternate with one idle cycle between grants
    begin
      logic [15:0] k0, k1;
      logic        n, prevN;
      k0 = 16'h0030; k1 = 16'h0040; prevN = 1'b1;
      for (int i = 0; i < 4; i++) begin
        n = (i % 2 == 1);
        applyStimulus(0, 1, k0, 1, 1, k1, 1, 1);
        checkOutput($sformatf("rr_gap%0d", i), 0, 0, 0, 16'h0, 0, prevN, 0);
        applyStimulus(0, 1, k0, 1, 1, k1, 1, 1);
        checkOutput($sformatf("rr_pkt%0d", i), ~n, n, 1, n ? k1 : k0, 1, n, 0);
        if (n) k1 = k1 + 16'h1; else k0 = k0 + 16'h1;
        prevN = n;
      end
    end

    // s01 waits through a stalled s00 packet
    applyStimulus(0, 1, 16'h0051, 0, 1, 16'h0060, 1, 1);
    checkOutput("stall_arb", 0, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(0, 1, 16'h0051, 0, 1, 16'h0060, 1, 1);
    checkOutput("stall_b1", 1, 0, 1, 16'h0051, 0, 0, 0);
    applyStimulus(0, 1, 16'h0052, 0, 1, 16'h0060, 1, 0);
    checkOutput("stall_b2_hold", 0, 0, 1, 16'h0052, 0, 0, 0);
    applyStimulus(0, 1, 16'h0052, 0, 1, 16'h0060, 1, 1);
    checkOutput("stall_b2", 1, 0, 1, 16'h0052, 0, 0, 0);
    applyStimulus(0, 1, 16'h0053, 1, 1, 16'h0060, 1, 0);
    checkOutput("stall_b3_hold", 0, 0, 1, 16'h0053, 1, 0, 0);
    applyStimulus(0, 1, 16'h0053, 1, 1, 16'h0060, 1, 1);
    checkOutput("stall_b3", 1, 0, 1, 16'h0053, 1, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0060, 1, 1);
    checkOutput("stall_gap", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0060, 1, 1);
    checkOutput("stall_s01", 0, 1, 1, 16'h0060, 1, 1, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("stall_idle", 0, 0, 0, 16'h0, 0, 1, 0);

    // Six beats without tlast: beat 4 is cut, beats 5-6 start a new packet
    applyStimulus(0, 1, 16'h0071, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_arb", 0, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(0, 1, 16'h0071, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_b1", 1, 0, 1, 16'h0071, 0, 0, 0);
    applyStimulus(0, 1, 16'h0072, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_b2", 1, 0, 1, 16'h0072, 0, 0, 0);
    applyStimulus(0, 1, 16'h0073, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_b3", 1, 0, 1, 16'h0073, 0, 0, 0);
    applyStimulus(0, 1, 16'h0074, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_b4_cut", 1, 0, 1, 16'h0074, 1, 0, 0);
    applyStimulus(0, 1, 16'h0075, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_rearb", 0, 0, 0, 16'h0, 0, 0, 1);
    applyStimulus(0, 1, 16'h0075, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_b5", 1, 0, 1, 16'h0075, 0, 0, 1);
    applyStimulus(0, 1, 16'h0076, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_b6", 1, 0, 1, 16'h0076, 0, 0, 1);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0099, 1, 1);
    checkOutput("ovf_hold_grant", 1, 0, 0, 16'h0, 0, 0, 1);

    // Reset clears the sticky flag and the open grant
    applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_rst", 1, 0, 0, 16'h0, 0, 0, 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("ovf_cleared", 0, 0, 0, 16'h0, 0, 0, 0);

    // Reset on beat 2 of a 5-beat packet, then a fresh s01 packet
    applyStimulus(0, 1, 16'h0081, 0, 0, 16'h0, 0, 1);
    checkOutput("mid_arb", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0081, 0, 0, 16'h0, 0, 1);
    checkOutput("mid_b1", 1, 0, 1, 16'h0081, 0, 0, 0);
    applyStimulus(1, 1, 16'h0082, 0, 0, 16'h0, 0, 1);
    checkOutput("mid_b2", 1, 0, 1, 16'h0082, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0091, 1, 1);
    checkOutput("mid_after_rst", 0, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0091, 1, 1);
    checkOutput("mid_s01", 0, 1, 1, 16'h0091, 1, 1, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkOutput("mid_idle", 0, 0, 0, 16'h0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_pkt_arbiter.md
FIR_PKT_ARBITER -- requirements
Module: fir_pkt_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: tdata width of all streams.
REQ-002 Parameter MAX_BEATS, default 256: longest legal packet in beats; must be ≥2.
REQ-003 Port aclk, input, 1: the block's only clock; all logic is on the rising edge.
REQ-004 Port areset, input, 1: reset, synchronous and active-high.
REQ-005 Ports s00_axis_tdata/tvalid/tlast, input, DATA_WIDTH/1/1: requester-0 stream.
REQ-006 Port s00_axis_tready, output, 1: requester-0 ready.
REQ-007 Ports s01_axis_tdata/tvalid/tlast, input, DATA_WIDTH/1/1: requester-1 stream.
REQ-008 Port s01_axis_tready, output, 1: requester-1 ready.
REQ-009 Ports m00_axis_tdata/tvalid/tlast, output, DATA_WIDTH/1/1: stream to the shared FIR.
REQ-010 Port m00_axis_tuser, output, 1: index of the granted requester.
REQ-011 Port m00_axis_tready, input, 1: FIR ready.
REQ-012 Port ovf_err, output, 1: sticky flag; a packet exceeded MAX_BEATS.

Function
REQ-013 FSM states SHALL be IDLE, GRANT0 and GRANT1, stored in a register.
REQ-014 Priority pointer prio, 1 bit, SHALL name the requester favoured on contention.
REQ-015 In IDLE, all treadys and m00_axis_tvalid SHALL be 0.
REQ-016 IDLE with exactly one input tvalid=1 -> next state is that requester's GRANT.
REQ-017 IDLE with both tvalid=1 -> next state is GRANT<prio>.
REQ-018 IDLE with neither tvalid -> stay IDLE.
REQ-019 Arbitration latency SHALL be exactly 1 cycle: the first beat can transfer in the cycle after the decision.
REQ-020 In GRANTn, m00_axis_tdata/tvalid/tlast SHALL pass through combinationally from sn.
REQ-021 In GRANTn, sn_axis_tready = m00_axis_tready, and the other tready = 0.
REQ-022 In GRANTn, m00_axis_tuser = n; in IDLE it holds the last granted index.
REQ-023 A beat is accepted when m00_axis_tvalid & m00_axis_tready.
REQ-024 Beat counter (width clog2(MAX_BEATS)) SHALL clear on grant and increment per accepted beat.
REQ-025 An accepted beat with tlast=1 -> next state IDLE, prio <= ~n.
REQ-026 The grant SHALL never change mid-packet, whatever the other requester's tvalid.
REQ-027 Overflow: accepted beat with count = MAX_BEATS-1 and input tlast=0 -> force m00_axis_tlast=1 on that beat, set ovf_err, go IDLE, prio <= ~n.
REQ-028 After an overflow, the remaining beats of the truncated packet are arbitrated as a new packet.
REQ-029 ovf_err SHALL clear only on reset.
REQ-030 Data is never dropped, duplicated or reordered within a requester.
REQ-031 Stalls (m00_axis_tready=0) SHALL hold state and counter unchanged.

Reset
REQ-032 areset=1 at a clock edge -> state IDLE, prio=0, counter=0, tuser register=0, ovf_err=0.
REQ-033 During and after reset, all treadys and m00_axis_tvalid SHALL be 0 until a grant is issued.
REQ-034 Reset mid-packet SHALL abandon the packet with no forced tlast; the next packet restarts arbitration.

Verification
REQ-035 Reset, then s00 sends a 3-beat packet 0x0001..0x0003 with m00 ready -> grant after 1 cycle; m00 sees 1,2,3 with tlast on 3 and tuser=0; IDLE follows.
REQ-036 s00 and s01 valid in the same cycle after reset -> s00 served first, then s01; s01 packet has tuser=1.
REQ-037 Both requesters continuously back-to-back -> packets alternate s00, s01, s00, ...; IDLE gap of exactly 1 cycle between packets.
REQ-038 s01 asserts valid during an s00 packet while m00_axis_tready toggles 1,0,1 -> s00 packet completes intact; s01_axis_tready=0 throughout.
REQ-039 MAX_BEATS=4 and s00 sends 6 beats with no tlast -> m00 beat 4 has tlast=1 and ovf_err=1; beats 5-6 re-arbitrate as a new packet; ovf_err stays 1.
REQ-040 Reset asserted on beat 2 of 5 -> all outputs idle the next cycle and ovf_err=0; a fresh s01 packet is then granted normally.
